// File: rtl/line_draw_fsm.sv
// line_draw_fsm
// VGA line-drawing controller. After reset it clears the whole frame to
// BG_COLOR, then rasterises line requests with an all-octant Bresenham engine,
// one pixel per clock, and offers a start/busy/done handshake.
// Optional build macro: LINE_CHAIN_EN. When defined, each line starts at the
// previous line's clamped endpoint (origin after CLEAR/reset) and x0/y0 are
// ignored. The port list is identical in both builds.
module line_draw_fsm #(
    parameter int                 H_RES    = 160,
    parameter int                 V_RES    = 120,
    parameter int                 CW       = 9,
    parameter int                 COLOR_W  = 3,
    parameter logic [COLOR_W-1:0] BG_COLOR = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [CW-1:0]      x0,
    input  logic [CW-1:0]      y0,
    input  logic [CW-1:0]      x1,
    input  logic [CW-1:0]      y1,
    input  logic [COLOR_W-1:0] input_color,
    output logic [CW-1:0]      x_out,
    output logic [CW-1:0]      y_out,
    output logic [COLOR_W-1:0] color,
    output logic               write_out,
    output logic               busy,
    output logic               done
);

    localparam logic [CW-1:0] X_MAX = CW'(H_RES - 1);
    localparam logic [CW-1:0] Y_MAX = CW'(V_RES - 1);
    localparam logic [CW-1:0] ONE   = CW'(1);

    // Engine arithmetic is signed and two bits wider than a coordinate so
    // that 2*err and the differences never overflow.
    typedef logic signed [CW+1:0] eng_t;

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_LOAD,
        S_DRAW,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               r_rst_hold;    // reset seen low last edge: hold CLEAR silent

    logic [CW-1:0]      r_x;           // scan counter in CLEAR, pen position in DRAW
    logic [CW-1:0]      r_y;
    logic [CW-1:0]      r_x1;
    logic [CW-1:0]      r_y1;
    eng_t               r_dx;
    eng_t               r_dy;          // stored negative: -|y1-y0|
    eng_t               r_err;
    logic               r_sx_neg;
    logic               r_sy_neg;
    logic [COLOR_W-1:0] r_color;

    logic [CW-1:0]      w_ld_x0;
    logic [CW-1:0]      w_ld_y0;
    logic [CW-1:0]      w_ld_x1;
    logic [CW-1:0]      w_ld_y1;
    eng_t               w_dif_x;
    eng_t               w_dif_y;
    eng_t               w_adx;
    eng_t               w_ady;
    eng_t               w_e2;
    eng_t               w_err_next;
    logic               w_step_x;
    logic               w_step_y;
    logic               w_at_end;
    logic               w_clear_last;

    function automatic logic [CW-1:0] clamp_x(input logic [CW-1:0] v);
        return (v > X_MAX) ? X_MAX : v;
    endfunction

    function automatic logic [CW-1:0] clamp_y(input logic [CW-1:0] v);
        return (v > Y_MAX) ? Y_MAX : v;
    endfunction

    function automatic eng_t ext(input logic [CW-1:0] v);
        return eng_t'({2'b00, v});
    endfunction

`ifdef LINE_CHAIN_EN
    logic [CW-1:0] r_chain_x;
    logic [CW-1:0] r_chain_y;

    // Remember each line's clamped endpoint; reset and CLEAR return it to the origin.
    always_ff @(posedge clk) begin
        if (!reset || r_state == S_CLEAR) begin
            r_chain_x <= '0;
            r_chain_y <= '0;
        end else if (r_state == S_LOAD) begin
            r_chain_x <= w_ld_x1;
            r_chain_y <= w_ld_y1;
        end
    end
`endif

    // State register; the hold flag keeps CLEAR from writing while reset is low.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples the pre-edge values; blocking here would create ordering races.
        if (!reset) begin
            r_state    <= S_CLEAR;
            r_rst_hold <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_rst_hold <= 1'b0;
        end
    end

    // Next-state and state-decoded outputs; nothing here depends on start
    // except the IDLE transition, so start never reaches write_out combinationally.
    always_comb begin
        // NOTE: every output gets a default before the case so that no path
        // leaves a signal unassigned, which would otherwise infer a latch.
        w_state_next = r_state;
        x_out        = '0;
        y_out        = '0;
        color        = '0;
        write_out    = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_CLEAR: begin
                x_out     = r_x;
                y_out     = r_y;
                color     = BG_COLOR;
                write_out = !r_rst_hold;
                busy      = 1'b1;
                if (!r_rst_hold && w_clear_last) begin
                    w_state_next = S_IDLE;
                end
            end
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                busy         = 1'b1;
                w_state_next = S_DRAW;
            end
            S_DRAW: begin
                x_out     = r_x;
                y_out     = r_y;
                color     = r_color;
                write_out = 1'b1;
                busy      = 1'b1;
                if (w_at_end) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_CLEAR;
            end
        endcase
    end

    // Clamped endpoints and Bresenham set-up terms presented to LOAD.
    always_comb begin
        w_ld_x1 = clamp_x(x1);
        w_ld_y1 = clamp_y(y1);
`ifdef LINE_CHAIN_EN
        w_ld_x0 = r_chain_x;
        w_ld_y0 = r_chain_y;
`else
        w_ld_x0 = clamp_x(x0);
        w_ld_y0 = clamp_y(y0);
`endif
        w_dif_x = ext(w_ld_x1) - ext(w_ld_x0);
        w_dif_y = ext(w_ld_y1) - ext(w_ld_y0);
        w_adx   = w_dif_x[CW+1] ? -w_dif_x : w_dif_x;
        w_ady   = w_dif_y[CW+1] ? -w_dif_y : w_dif_y;
    end

    // One Bresenham step: both axis updates may apply in the same cycle,
    // each judged against the same e2.
    always_comb begin
        w_e2       = r_err <<< 1;
        w_step_x   = (w_e2 >= r_dy);
        w_step_y   = (w_e2 <= r_dx);
        w_err_next = r_err;
        if (w_step_x) begin
            w_err_next = w_err_next + r_dy;
        end
        if (w_step_y) begin
            w_err_next = w_err_next + r_dx;
        end
        w_at_end     = (r_x == r_x1) && (r_y == r_y1);
        w_clear_last = (r_x == X_MAX) && (r_y == Y_MAX);
    end

    // Datapath: raster scan in CLEAR, engine load in LOAD, pen step in DRAW.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_x      <= '0;
            r_y      <= '0;
            r_x1     <= '0;
            r_y1     <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_err    <= '0;
            r_sx_neg <= 1'b0;
            r_sy_neg <= 1'b0;
            r_color  <= '0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    if (!r_rst_hold) begin
                        if (w_clear_last) begin
                            r_x <= '0;
                            r_y <= '0;
                        end else if (r_x == X_MAX) begin
                            r_x <= '0;
                            r_y <= r_y + ONE;
                        end else begin
                            r_x <= r_x + ONE;
                        end
                    end
                end
                S_LOAD: begin
                    r_x      <= w_ld_x0;
                    r_y      <= w_ld_y0;
                    r_x1     <= w_ld_x1;
                    r_y1     <= w_ld_y1;
                    r_dx     <= w_adx;
                    r_dy     <= -w_ady;
                    r_err    <= w_adx - w_ady;
                    r_sx_neg <= !(w_ld_x0 < w_ld_x1);
                    r_sy_neg <= !(w_ld_y0 < w_ld_y1);
                    r_color  <= input_color;
                end
                S_DRAW: begin
                    if (!w_at_end) begin
                        if (w_step_x) begin
                            r_x <= r_sx_neg ? (r_x - ONE) : (r_x + ONE);
                        end
                        if (w_step_y) begin
                            r_y <= r_sy_neg ? (r_y - ONE) : (r_y + ONE);
                        end
                        r_err <= w_err_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_draw_fsm.sv
// tb_line_draw_fsm
// Directed and random line requests against a point-list reference model;
// also covers the power-on clear pass and a reset dropped mid-line.
// Compile with +define+LINE_CHAIN_EN to exercise the chained build.
module tb_line_draw_fsm;

    localparam int H_RES   = 160;
    localparam int V_RES   = 120;
    localparam int CW      = 9;
    localparam int COLOR_W = 3;

    logic               clk         = 1'b0;
    logic               reset       = 1'b0;
    logic               start       = 1'b0;
    logic [CW-1:0]      x0          = '0;
    logic [CW-1:0]      y0          = '0;
    logic [CW-1:0]      x1          = '0;
    logic [CW-1:0]      y1          = '0;
    logic [COLOR_W-1:0] input_color = '0;
    logic [CW-1:0]      x_out;
    logic [CW-1:0]      y_out;
    logic [COLOR_W-1:0] color;
    logic               write_out;
    logic               busy;
    logic               done;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: expected pixel list of the pending line.
    int ex_q[$];
    int ey_q[$];
    int m_npix = 0;
    int m_cx   = 0;
    int m_cy   = 0;

    line_draw_fsm #(
        .H_RES   (H_RES),
        .V_RES   (V_RES),
        .CW      (CW),
        .COLOR_W (COLOR_W),
        .BG_COLOR(3'd0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .x0         (x0),
        .y0         (y0),
        .x1         (x1),
        .y1         (y1),
        .input_color(input_color),
        .x_out      (x_out),
        .y_out      (y_out),
        .color      (color),
        .write_out  (write_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int clampx(input int v);
        return (v > H_RES - 1) ? H_RES - 1 : v;
    endfunction

    function automatic int clampy(input int v);
        return (v > V_RES - 1) ? V_RES - 1 : v;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Plain-integer Bresenham walk producing the full expected point list.
    task automatic model_line(input int ax0, input int ay0, input int ax1, input int ay1);
        int x, y, xe, ye, dx, dy, sx, sy, err, e2;
        ex_q.delete();
        ey_q.delete();
        xe = clampx(ax1);
        ye = clampy(ay1);
`ifdef LINE_CHAIN_EN
        x = m_cx;
        y = m_cy;
`else
        x = clampx(ax0);
        y = clampy(ay0);
`endif
        m_npix = ((iabs(xe - x) > iabs(ye - y)) ? iabs(xe - x) : iabs(ye - y)) + 1;
        dx  = iabs(xe - x);
        dy  = -iabs(ye - y);
        sx  = (x < xe) ? 1 : -1;
        sy  = (y < ye) ? 1 : -1;
        err = dx + dy;
        for (int n = 0; n < 1000; n++) begin
            ex_q.push_back(x);
            ey_q.push_back(y);
            if (x == xe && y == ye) break;
            e2 = 2 * err;
            if (e2 >= dy) begin
                err += dy;
                x   += sx;
            end
            if (e2 <= dx) begin
                err += dx;
                y   += sy;
            end
        end
        m_cx = xe;
        m_cy = ye;
    endtask

    // Called at a negedge with the DUT in IDLE; returns at the LOAD-cycle negedge.
    task automatic issue(input int ax0, input int ay0, input int ax1, input int ay1,
                         input int col, input bit hold);
        model_line(ax0, ay0, ax1, ay1);
        x0          = CW'(ax0);
        y0          = CW'(ay0);
        x1          = CW'(ax1);
        y1          = CW'(ay1);
        input_color = COLOR_W'(col);
        start       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("load_cycle", {29'd0, done, busy, write_out}, 32'b010);
        if (!hold) start = 1'b0;
    endtask

    // Collects the pixel burst that follows LOAD and checks the done pulse.
    task automatic collect_line(input int col, input bit scramble);
        int n, offs;
        logic [31:0] obs, exp;
        @(negedge clk);
        check("first_pixel_latency", {31'd0, write_out}, 32'd1);
        if (scramble) begin
            x0          = CW'($urandom);
            y0          = CW'($urandom);
            x1          = CW'($urandom);
            y1          = CW'($urandom);
            input_color = COLOR_W'($urandom);
        end
        n    = 0;
        offs = 0;
        while (write_out === 1'b1 && n < 400) begin
            if (x_out >= H_RES || y_out >= V_RES) offs++;
            if (n < ex_q.size()) begin
                obs = {11'd0, x_out, y_out, color};
                exp = {11'd0, CW'(ex_q[n]), CW'(ey_q[n]), COLOR_W'(col)};
                check("pixel", obs, exp);
            end
            n++;
            @(negedge clk);
        end
        check("pixel_count", n, ex_q.size());
        check("pixel_count_formula", n, m_npix);
        check("pixels_on_screen", offs, 0);
        check("done_pulse", {29'd0, done, busy, write_out}, 32'b100);
        @(negedge clk);
        check("after_done_idle", {29'd0, done, busy, write_out}, 32'b000);
    endtask

    // Called at the negedge where reset is released; follows the whole clear pass.
    task automatic wait_clear();
        int t, n, bad;
        logic [31:0] first_px, px160, last_px;
        m_cx     = 0;
        m_cy     = 0;
        first_px = '1;
        px160    = '1;
        last_px  = '1;
        t = 0;
        while (write_out !== 1'b1 && t < 8) begin
            @(negedge clk);
            t++;
        end
        n   = 0;
        bad = 0;
        while (write_out === 1'b1 && n < 20000) begin
            if (x_out !== CW'(n % H_RES) || y_out !== CW'(n / H_RES) || color !== 3'd0) bad++;
            if (n == 0)   first_px = {14'd0, x_out, y_out};
            if (n == 160) px160    = {14'd0, x_out, y_out};
            last_px = {14'd0, x_out, y_out};
            n++;
            @(negedge clk);
        end
        check("clear_write_count", n, H_RES * V_RES);
        check("clear_raster_errors", bad, 0);
        check("clear_first_pixel", first_px, {14'd0, 9'd0, 9'd0});
        check("clear_pixel_160", px160, {14'd0, 9'd0, 9'd1});
        check("clear_last_pixel", last_px, {14'd0, 9'd159, 9'd119});
        check("idle_outputs", {8'd0, x_out, y_out, color, write_out, busy, done},
              {8'd0, 9'd0, 9'd0, 3'd0, 1'b0, 1'b0, 1'b0});
    endtask

    initial begin
        int col, n, t;

        // Reset values, then the power-on clear pass.
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {8'd0, x_out, y_out, color, write_out, busy, done},
              {8'd0, 9'd0, 9'd0, 3'd0, 1'b0, 1'b1, 1'b0});
        reset = 1'b1;
        wait_clear();

        // Directed lines.
        issue(10, 10, 20, 15, 5, 1'b0);
        collect_line(5, 1'b1);
        issue(5, 50, 5, 40, 2, 1'b0);
        collect_line(2, 1'b1);
        issue(200, 300, 0, 0, 7, 1'b0);
        collect_line(7, 1'b1);
        issue(7, 7, 7, 7, 1, 1'b0);
        collect_line(1, 1'b1);
        issue(150, 3, 12, 110, 6, 1'b0);
        collect_line(6, 1'b1);

        // Start held high through the line: ignored until IDLE, then retaken.
        issue(3, 100, 40, 90, 4, 1'b1);
        collect_line(4, 1'b0);
        @(negedge clk);
        check("held_start_reload", {29'd0, done, busy, write_out}, 32'b010);
        start = 1'b0;
        model_line(3, 100, 40, 90);
        collect_line(4, 1'b1);

        // Random lines, including off-screen endpoints that must clamp.
        for (int i = 0; i < 12; i++) begin
            col = $urandom_range(0, 7);
            issue($urandom_range(0, 199), $urandom_range(0, 149),
                  $urandom_range(0, 199), $urandom_range(0, 149), col, 1'b0);
            collect_line(col, 1'b1);
        end

        // Reset dropped at the fourth pixel of a line.
        issue(0, 0, 100, 0, 3, 1'b0);
        n = 0;
        t = 0;
        while (n < 4 && t < 20) begin
            @(negedge clk);
            t++;
            if (write_out === 1'b1) n++;
        end
        check("midline_reached_pixel4", n, 4);
        reset = 1'b0;
        @(negedge clk);
        check("midline_reset_outputs", {8'd0, x_out, y_out, color, write_out, busy, done},
              {8'd0, 9'd0, 9'd0, 3'd0, 1'b0, 1'b1, 1'b0});
        reset = 1'b1;
        wait_clear();

`ifdef LINE_CHAIN_EN
        // Chained requests ignore x0/y0 and start from the origin after CLEAR.
        issue(99, 99, 30, 30, 3, 1'b0);
        collect_line(3, 1'b1);
        issue(99, 99, 30, 60, 5, 1'b0);
        collect_line(5, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/line_draw_fsm.md
# line_draw_fsm

Parametrised line-drawing controller for the VGA pixel path. After reset it clears the frame to a background colour. It then accepts line requests between two arbitrary endpoints and rasterises each one with an integrated all-octant Bresenham engine, emitting one pixel per cycle. It drives the VGA adapter's x/y/colour/plot inputs and offers a start/busy/done handshake to the user-input logic.

## Interface
- H_RES, 160, visible width in pixels; legal x range is 0..H_RES-1.
- V_RES, 120, visible height in pixels; legal y range is 0..V_RES-1.
- CW, 9, coordinate width; must satisfy 2^CW > max(H_RES, V_RES).
- COLOR_W, 3, colour width.
- BG_COLOR, 0, colour written during the clear pass.
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low reset (sampled on the rising edge of clk).
- start  in  1  line request; sampled only in IDLE.
- x0, y0  in  CW each  line start point.
- x1, y1  in  CW each  line end point.
- input_color  in  COLOR_W  line colour.
- x_out, y_out  out  CW each  pixel coordinate to the VGA adapter.
- color  out  COLOR_W  pixel colour.
- write_out  out  1  pixel write strobe; the pixel is valid only when this is 1.
- busy  out  1  high in CLEAR, LOAD and DRAW.
- done  out  1  one-cycle pulse when a line finishes.

## Operation
- States and transitions:
  - CLEAR → IDLE after the last pixel.
  - IDLE → LOAD on start=1.
  - LOAD → DRAW.
  - DRAW → DONE after the endpoint pixel is emitted.
  - DONE → IDLE.
- reset=0 forces CLEAR from any state and clears all registers, including mid-line. Any line in progress is abandoned.
- CLEAR:
  - Raster scan with x fastest: x goes 0..H_RES-1, then y increments, from (0,0) to (H_RES-1,V_RES-1).
  - Outputs: write_out=1, color=BG_COLOR, x_out/y_out = scan counters.
- IDLE:
  - Outputs: x_out=0, y_out=0, color=0, write_out=0, busy=0.
  - start is ignored in every state except IDLE.
- LOAD:
  - Latches the endpoints and input_color. Inputs may change freely after this cycle.
  - Clamps each coordinate independently: x>H_RES-1 becomes H_RES-1; y>V_RES-1 becomes V_RES-1.
  - Computes the engine terms:
    - dx=|x1-x0|, dy=-|y1-y0|.
    - sx=+1 if x0<x1, else -1; sy likewise.
    - err=dx+dy.
  - All engine arithmetic is signed, CW+2 bits wide. It never overflows for legal parameters.
  - Outputs: write_out=0.
- DRAW:
  - Each cycle outputs the current (x,y) with write_out=1 and the latched colour.
  - If (x,y)=(x1,y1), go to DONE. Otherwise, with e2=2·err:
    - if e2≥dy: err+=dy, x+=sx;
    - if e2≤dx: err+=dx, y+=sy.
    - Both updates apply in the same cycle when both conditions hold.
  - Pixels per line = max(|Δx|,|Δy|)+1.
  - A degenerate line (start=end) emits exactly one pixel.
- DONE:
  - Outputs: done=1, write_out=0, busy=0.
  - If start is still high, a new request is taken one cycle later in IDLE.
- Every coordinate emitted lies within the clamped screen.

## Timing
- Reset values of outputs, applied the cycle after reset is sampled low:
  - x_out=0, y_out=0, color=BG_COLOR, write_out=0, busy=1, done=0.
- Once reset is released, CLEAR emits H_RES·V_RES write cycles, one pixel per cycle, then enters IDLE.
- Line latency:
  - start sampled in IDLE at edge k → LOAD during cycle k+1 → first pixel during cycle k+2.
  - Last pixel during cycle k+1+N (N = pixel count); done during cycle k+2+N.
- Throughput: one pixel per clock, with no stalls.
- Outputs are registered or state-decoded; there is no combinational path from start to write_out.

## Configuration
- LINE_CHAIN_EN defined:
  - In LOAD, the start point is the previous line's clamped endpoint; x0/y0 are ignored.
  - After CLEAR, the chained start point is (0,0).
  - reset returns the chained start point to (0,0).
- LINE_CHAIN_EN undefined:
  - x0/y0 are used as given, after clamping.
  - The x0/y0 ports still exist, so the port list is identical in both builds.

## Test plan
- Reset then release, H_RES=160, V_RES=120:
  - Exactly 19200 writes of colour 0.
  - First pixel (0,0), pixel 160 is (0,1), last pixel (159,119), then IDLE with busy=0.
- Line (10,10)→(20,15), colour 5:
  - 11 pixels, first (10,10), last (20,15), x strictly increasing.
  - Writes begin 2 cycles after start; done pulses once, 1 cycle after the last pixel.
- Line (5,50)→(5,40), steep negative:
  - 11 pixels with y running 50 down to 40 and x fixed at 5.
- Line (200,300)→(0,0):
  - Start is clamped to (159,119).
  - 160 pixels, all on-screen, ending at (0,0).
- Drop reset low at pixel 4 of line (0,0)→(100,0):
  - write_out goes low the next cycle.
  - On release, a full CLEAR restarts at (0,0); no further line pixels appear.
- With LINE_CHAIN_EN, requests to (30,30) then (30,60), x0/y0 driven to 99:
  - Line 1 runs (0,0)→(30,30).
  - Line 2 runs (30,30)→(30,60), 31 pixels.
